rf_wb_arbiter: RTL

- Shares the single register-file write port between two writeback sources.
- Port 0 is the in-order pipeline writeback. Port 1 is a long-latency unit (load/mul-div).
- Fixed priority to port 0, with a starvation limit that forces a port-1 grant.
- Output is registered: one write stage between the arbiter and the register file's rd_addr/rd_data/RegWrite inputs.

---
 rtl/rf_wb_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: port 0 has fixed priority, port 1 is forced after STARVE_MAX waits.
// Optional read-port forwarding of the write stage is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32,
  parameter int STARVE_MAX = 4,
  localparam int AW = $clog2(REG_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_valid_i,
  output logic                  p0_ready_o,
  input  logic [AW-1:0]         p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  input  logic                  p1_valid_i,
  output logic                  p1_ready_o,
  input  logic [AW-1:0]         p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  output logic                  rf_we_o,
  output logic [AW-1:0]         rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
`ifdef RF_WB_FWD_EN
  input  logic [AW-1:0]         rs1_addr_i,
  input  logic [AW-1:0]         rs2_addr_i,
  input  logic [DATA_WIDTH-1:0] rs1_rf_i,
  input  logic [DATA_WIDTH-1:0] rs2_rf_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
`endif
  output logic [7:0]            starve_cnt_o
);

  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [AW-1:0]         rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic                  force1;
  logic                  p0_fire, p1_fire;

  assign force1     = (starve_cnt_q == 8'(STARVE_MAX));
  assign p0_ready_o = !force1;
  assign p1_ready_o = force1 || !p0_valid_i;
  // The ready terms are mutually exclusive whenever both ports request, so at most one fires.
  assign p0_fire    = p0_valid_i && p0_ready_o;
  assign p1_fire    = p1_valid_i && p1_ready_o;

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (p0_fire && p0_addr_i != '0) begin
      rf_we_d   = 1'b1;
      rf_addr_d = p0_addr_i;
      rf_data_d = p0_data_i;
    end else if (p1_fire && p1_addr_i != '0) begin
      rf_we_d   = 1'b1;
      rf_addr_d = p1_addr_i;
      rf_data_d = p1_data_i;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p1_valid_i || p1_fire) begin
      starve_cnt_d = 8'd0;
    end else if (!force1) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= 8'd0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_o    = rf_data_q;
  assign starve_cnt_o = starve_cnt_q;

`ifdef RF_WB_FWD_EN
  // Readers in the same cycle as the write stage see the in-flight value.
  assign rs1_data_o = (rf_we_q && rf_addr_q == rs1_addr_i && rs1_addr_i != '0) ? rf_data_q : rs1_rf_i;
  assign rs2_data_o = (rf_we_q && rf_addr_q == rs2_addr_i && rs2_addr_i != '0) ? rf_data_q : rs2_rf_i;
`endif

endmodule
